mem_stage_lsu: RTL

Parametrised memory-access pipeline stage for the RISC-V core, sitting between EX and WB. It passes ALU results through with a registered one-cycle latency. Loads and stores run a two-state request/done handshake against the memory controller, with byte/half/word sizing, load sign/zero extension, store masking, misalignment trapping and a pipeline stall toward upstream stages.

---
 rtl/mem_stage_lsu.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
`timescale 1ns/1ps
// mem_stage_lsu
// Memory-access pipeline stage between EX and WB. Non-memory instructions
// pass through with one registered cycle of latency. Loads and stores run a
// request/done handshake with the memory controller (IDLE -> BUSY -> IDLE),
// with byte/half/word sizing, load sign/zero extension, store data masking
// and misalignment trapping. stall_out asks upstream to hold its inputs.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-high reset
//   rdy_in                  global ready; low freezes every register
//   in_*                    instruction from EX (rd_data doubles as address)
//   stall_out               combinational hold request to upstream
//   mem_*_out               registered request to the memory controller
//   mem_done_in/rdata_in    one-cycle completion pulse and load data
//   out_*                   registered result toward WB
module mem_stage_lsu #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  in_valid,
   input  logic [REG_ADDR_W-1:0] in_rd_addr,
   input  logic [XLEN-1:0]       in_rd_data,
   input  logic                  in_write_or_not,
   input  logic [1:0]            in_mem_op,
   input  logic [2:0]            in_funct3,
   input  logic [XLEN-1:0]       in_store_data,
   output logic                  stall_out,
   output logic                  mem_req_out,
   output logic                  mem_we_out,
   output logic [XLEN-1:0]       mem_addr_out,
   output logic [1:0]            mem_size_out,
   output logic [XLEN-1:0]       mem_wdata_out,
   input  logic                  mem_done_in,
   input  logic [XLEN-1:0]       mem_rdata_in,
   output logic                  out_valid,
   output logic [REG_ADDR_W-1:0] out_rd_addr,
   output logic [XLEN-1:0]       out_rd_data,
   output logic                  out_write_or_not,
   output logic                  out_misaligned
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state, next_state;

   logic                  is_mem;
   logic                  aligned;
   logic [1:0]            in_size;
   logic [XLEN-1:0]       wdata_masked;
   logic [XLEN-1:0]       load_ext;
   logic                  accept_alu;
   logic                  accept_mem;
   logic                  trap_mis;
   logic                  complete;

   // Request context kept for the result; out_rd_addr must not change while
   // the access is in flight.
   logic [REG_ADDR_W-1:0] lat_rd_addr;
   logic [2:0]            lat_funct3;
   logic                  lat_write;

   // Decode of the incoming instruction.
   always_comb begin
      is_mem = (in_mem_op == 2'b01) || (in_mem_op == 2'b10);

      case (in_funct3[1:0])
         2'b00:   in_size = 2'd0;
         2'b01:   in_size = 2'd1;
         default: in_size = 2'd2;
      endcase

      case (in_size)
         2'd0:    aligned = 1'b1;
         2'd1:    aligned = ~in_rd_data[0];
         default: aligned = (in_rd_data[1:0] == 2'b00);
      endcase

      case (in_size)
         2'd0:    wdata_masked = {{(XLEN-8){1'b0}},  in_store_data[7:0]};
         2'd1:    wdata_masked = {{(XLEN-16){1'b0}}, in_store_data[15:0]};
         default: wdata_masked = in_store_data;
      endcase
   end

   // Load extension uses the funct3 captured at request time.
   always_comb begin
      case (lat_funct3[1:0])
         2'b00:   load_ext = {{(XLEN-8){mem_rdata_in[7] & ~lat_funct3[2]}},
                              mem_rdata_in[7:0]};
         2'b01:   load_ext = {{(XLEN-16){mem_rdata_in[15] & ~lat_funct3[2]}},
                              mem_rdata_in[15:0]};
         default: load_ext = mem_rdata_in;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else if (rdy_in) begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      stall_out  = 1'b0;
      accept_alu = 1'b0;
      accept_mem = 1'b0;
      trap_mis   = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (is_mem) begin
                  if (aligned) begin
                     accept_mem = 1'b1;
                     stall_out  = 1'b1;
                     next_state = BUSY;
                  end else begin
                     trap_mis = 1'b1;
                  end
               end else begin
                  accept_alu = 1'b1;
               end
            end
         end
         BUSY: begin
            // Releasing the stall in the done cycle lets upstream present the
            // next instruction exactly when we return to IDLE.
            stall_out = ~mem_done_in;
            if (mem_done_in) begin
               complete   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      if (!rdy_in) begin
         stall_out = 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mem_req_out      <= 1'b0;
         mem_we_out       <= 1'b0;
         mem_addr_out     <= '0;
         mem_size_out     <= '0;
         mem_wdata_out    <= '0;
         out_valid        <= 1'b0;
         out_rd_addr      <= '0;
         out_rd_data      <= '0;
         out_write_or_not <= 1'b0;
         out_misaligned   <= 1'b0;
         lat_rd_addr      <= '0;
         lat_funct3       <= '0;
         lat_write        <= 1'b0;
      end else if (rdy_in) begin
         out_valid        <= 1'b0;
         out_write_or_not <= 1'b0;
         out_misaligned   <= 1'b0;

         if (accept_alu) begin
            out_valid        <= 1'b1;
            out_rd_addr      <= in_rd_addr;
            out_rd_data      <= in_rd_data;
            out_write_or_not <= in_write_or_not;
         end

         if (trap_mis) begin
            out_valid      <= 1'b1;
            out_misaligned <= 1'b1;
            out_rd_addr    <= in_rd_addr;
            out_rd_data    <= in_rd_data;
         end

         if (accept_mem) begin
            mem_req_out   <= 1'b1;
            mem_we_out    <= (in_mem_op == 2'b10);
            mem_addr_out  <= in_rd_data;
            mem_size_out  <= in_size;
            mem_wdata_out <= wdata_masked;
            lat_rd_addr   <= in_rd_addr;
            lat_funct3    <= in_funct3;
            lat_write     <= in_write_or_not;
         end

         if (complete) begin
            mem_req_out <= 1'b0;
            out_valid   <= 1'b1;
            out_rd_addr <= lat_rd_addr;
            if (mem_we_out) begin
               out_rd_data <= mem_addr_out;
            end else begin
               out_rd_data      <= load_ext;
               out_write_or_not <= lat_write;
            end
         end
      end
   end

endmodule
